cmul_seq: RTL and testbench

CMUL_SEQ -- requirements
Module: cmul_seq

---
 rtl/cmul_pkg.sv | 14 +
 rtl/mult.sv | 10 +
 rtl/cmul_seq.sv | 97 +++++++++
 tb/tb_cmul_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_pkg.sv
// Shared types and default widths for the sequential complex multiplier.
package cmul_pkg;
  localparam int CMUL_DW = 8;
  localparam int CMUL_PW = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } cmul_state_t;
endpackage

// File: rtl/mult.sv
// Combinational signed W x W multiplier with a full-width 2W product.
module mult #(
  parameter int W = 8
) (
  output logic signed [2*W-1:0] y,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b
);
  assign y = a * b;
endmodule

// File: rtl/cmul_seq.sv
// Sequential complex multiplier: P = A*Q over four passes through one shared
// signed multiplier, with a valid/ready handshake on both sides.
module cmul_seq
  import cmul_pkg::*;
#(
  parameter int DW = CMUL_DW,
  parameter int PW = 2*DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] rea,
  input  logic signed [DW-1:0] ima,
  input  logic signed [DW-1:0] req,
  input  logic signed [DW-1:0] imq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [PW-1:0] rep,
  output logic signed [PW-1:0] imp
);
  cmul_state_t state;

  logic signed [DW-1:0]   rea_r, ima_r, req_r, imq_r;
  logic signed [DW-1:0]   ma, mb;
  logic signed [2*DW-1:0] prod;
  logic signed [PW-1:0]   prod_x;
  logic signed [PW-1:0]   acc_re, acc_im;
  logic                   accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign rep       = acc_re;
  assign imp       = acc_im;

  // Operand pair for this pass: re uses (rea,req),(ima,imq); im uses (rea,imq),(ima,req).
  always_comb begin
    ma = rea_r;
    mb = req_r;
    case (state)
      P1:      begin ma = ima_r; mb = imq_r; end
      P2:      begin ma = rea_r; mb = imq_r; end
      P3:      begin ma = ima_r; mb = req_r; end
      default: begin ma = rea_r; mb = req_r; end
    endcase
  end

  mult #(.W(DW)) u_mult (
    .y (prod),
    .a (ma),
    .b (mb)
  );

  // Product resized to the accumulator width; arithmetic wraps silently.
  assign prod_x = PW'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rea_r  <= '0;
      ima_r  <= '0;
      req_r  <= '0;
      imq_r  <= '0;
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      if (accept) begin
        rea_r <= rea;
        ima_r <= ima;
        req_r <= req;
        imq_r <= imq;
      end
      case (state)
        IDLE: if (accept) state <= P0;
        P0: begin
          acc_re <= prod_x;
          state  <= P1;
        end
        P1: begin
          acc_re <= acc_re - prod_x;
          state  <= P2;
        end
        P2: begin
          acc_im <= prod_x;
          state  <= P3;
        end
        P3: begin
          acc_im <= acc_im + prod_x;
          state  <= DONE;
        end
        DONE: if (out_ready) state <= accept ? P0 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmul_seq.sv
// Directed and randomized checks for cmul_seq against hand-computed results
// and a 16-bit wrapped complex multiply model.
module tb_cmul_seq;
  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] rea, ima, req, imq;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] rep, imp;

  int n_checks = 0;
  int n_fail   = 0;

  cmul_seq #(.DW(8), .PW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rea       (rea),
    .ima       (ima),
    .req       (req),
    .imq       (imq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rep       (rep),
    .imp       (imp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cref(input logic signed [7:0] a, b, c, d);
    int ia, ib, ic, id, r, i;
    ia = a; ib = b; ic = c; id = d;
    r = ia*ic - ib*id;
    i = ia*id + ib*ic;
    return {r[15:0], i[15:0]};
  endfunction

  task automatic set_ops(input logic signed [7:0] a, b, c, d);
    rea = a; ima = b; req = c; imq = d;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rep !== 16'sd0 || imp !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b in_ready=%b rep=%0d imp=%0d, want 0 1 0 0",
               out_valid, in_ready, rep, imp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    @(posedge clk); #1;
    set_ops(3, 4, 1, 2);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: out_valid=%b after 4 edges, want 0", out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || rep !== -16'sd5 || imp !== 16'sd10) begin
      n_fail++;
      $display("FAIL basic_result: out_valid=%b rep=%0d imp=%0d, want 1 -5 10",
               out_valid, rep, imp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_corner;
    logic signed [7:0]  va [2] = '{-8'sd128, 8'sd127};
    logic signed [15:0] wr [2] = '{16'sd0, 16'sd0};
    logic signed [15:0] wi [2] = '{-16'sd32768, 16'sd32258};
    for (int k = 0; k < 2; k++) begin
      int cyc = 0;
      set_ops(va[k], va[k], va[k], va[k]);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || rep !== wr[k] || imp !== wi[k]) begin
        n_fail++;
        $display("FAIL corner_%0d: out_valid=%b rep=%0d imp=%0d, want 1 %0d %0d",
                 k, out_valid, rep, imp, wr[k], wi[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int cyc = 0;
    int bad = 0;
    set_ops(2, 1, -3, 5);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // New operands offered during the stall must be ignored.
    set_ops(9, 9, 9, 9);
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rep !== -16'sd11 || imp !== 16'sd7) begin
        n_fail++; bad++;
        if (bad < 4)
          $display("FAIL stall_%0d: out_valid=%b in_ready=%b rep=%0d imp=%0d, want 1 0 -11 7",
                   i, out_valid, in_ready, rep, imp);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: in_ready=%b, want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL release_single_%0d: out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic signed [7:0]  oa [3] = '{8'sd1, -8'sd7, 8'sd100};
    logic signed [7:0]  ob [3] = '{8'sd2, 8'sd3, -8'sd50};
    logic signed [7:0]  oc [3] = '{8'sd3, 8'sd2, -8'sd20};
    logic signed [7:0]  od [3] = '{8'sd4, -8'sd5, 8'sd90};
    logic signed [15:0] wr [3] = '{-16'sd5, 16'sd1, 16'sd2500};
    logic signed [15:0] wi [3] = '{16'sd10, 16'sd41, 16'sd10000};
    int sidx = 0, ridx = 0, cyc = 0, last = -1;
    logic acc;
    out_ready = 1'b1;
    set_ops(oa[0], ob[0], oc[0], od[0]);
    in_valid = 1'b1;
    while (ridx < 3 && cyc < 60) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_checks++;
        if (rep !== wr[ridx] || imp !== wi[ridx]) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: rep=%0d imp=%0d, want %0d %0d",
                   ridx, rep, imp, wr[ridx], wi[ridx]);
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing_%0d: gap=%0d, want 5", ridx, cyc - last);
          end
        end
        last = cyc;
        ridx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sidx++;
        if (sidx < 3) set_ops(oa[sidx], ob[sidx], oc[sidx], od[sidx]);
        else in_valid = 1'b0;
      end
    end
    n_checks++;
    if (ridx != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, want 3", ridx);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int cyc = 0;
    int seen = 0;
    set_ops(3, 4, 1, 2);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;   // now in P2
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rep !== 16'sd0 || imp !== 16'sd0) begin
      n_fail++;
      $display("FAIL midop_rst: out_valid=%b in_ready=%b rep=%0d imp=%0d, want 0 1 0 0",
               out_valid, in_ready, rep, imp);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midop_abandon: out_valid high %0d cycles, want 0", seen);
    end
    set_ops(-5, 7, 6, -2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || rep !== -16'sd16 || imp !== 16'sd52) begin
      n_fail++;
      $display("FAIL midop_next: out_valid=%b rep=%0d imp=%0d, want 1 -16 52",
               out_valid, rep, imp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    localparam int N = 2000;
    logic [31:0] q[$];
    logic [31:0] exp_v;
    int sent = 0, got = 0, cyc = 0, bad = 0;
    logic acc;
    in_valid = 1'b0;
    while (got < N && cyc < 60000) begin
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        set_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(cref(rea, ima, req, imq));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; bad++;
          if (bad < 5) $display("FAIL rand_extra: result rep=%0d imp=%0d with none pending", rep, imp);
        end else begin
          exp_v = q.pop_front();
          if ({rep, imp} !== exp_v) begin
            n_fail++; bad++;
            if (bad < 5)
              $display("FAIL rand_result_%0d: rep=%0d imp=%0d, want %0d %0d", got, rep, imp,
                       $signed(exp_v[31:16]), $signed(exp_v[15:0]));
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    n_checks++;
    if (got != N || sent != N || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: sent=%0d got=%0d pending=%0d, want %0d %0d 0",
               sent, got, q.size(), N, N);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_ops(0, 0, 0, 0);
    test_reset;
    test_basic;
    test_corner;
    test_backpressure;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
